// File: rtl/fp_align_shifter.sv
// fp_align_shifter: alignment stage of the floating-point adder.
// Picks the larger-exponent operand as "big" and right-shifts the other
// mantissa iteratively. The shifted-out bits collapse into a guard/round/sticky
// tail so that the mantissa adder can round correctly.
// Optional build macro: ALIGN_COARSE_EN. When it is defined, the shifter
// moves 4 bits per cycle while at least 4 remain. The final result does not
// change, only the latency.
module fp_align_shifter #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [EXP_W-1:0]    i_exp_diff,
    input  logic                i_a_ge_b,
    input  logic [EXP_W-1:0]    i_exp_a,
    input  logic [EXP_W-1:0]    i_exp_b,
    input  logic [MANT_W-1:0]   i_man_a,
    input  logic [MANT_W-1:0]   i_man_b,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [EXP_W-1:0]    o_exp_out,
    output logic [MANT_W-1:0]   o_man_big,
    output logic [MANT_W+2:0]   o_man_small,
    output logic                o_swapped
);

    // Width of the aligned mantissa including the G/R/S tail, and the counter
    // width needed to hold a saturated shift amount of SW.
    localparam int SW    = MANT_W + 3;
    localparam int CNT_W = $clog2(SW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_init;
    logic [CNT_W-1:0]   w_cnt_step;
    logic [SW-1:0]      r_man_small;
    logic [SW-1:0]      w_man_small_step;
    logic [EXP_W-1:0]   r_exp_out;
    logic [MANT_W-1:0]  r_man_big;
    logic               r_swapped;
    logic               r_out_valid;
    logic               w_accept;
    logic               w_shifting;

    assign o_in_ready  = (r_state == S_IDLE);
    assign w_accept    = (r_state == S_IDLE) && i_in_valid;
    assign w_shifting  = (r_state == S_SHIFT) && (r_cnt != '0);

    assign o_out_valid = r_out_valid;
    assign o_exp_out   = r_exp_out;
    assign o_man_big   = r_man_big;
    assign o_man_small = r_man_small;
    assign o_swapped   = r_swapped;

    // Any shift of SW or more leaves only sticky, so clamp the count there.
    always_comb begin
        w_cnt_init = CNT_W'(i_exp_diff);
        if (32'(i_exp_diff) >= 32'(SW)) begin
            w_cnt_init = CNT_W'(SW);
        end
    end

    // One shift step. Bits that fall off the bottom are ORed into the sticky
    // bit, so no information about a nonzero remainder is ever lost.
    always_comb begin
        w_man_small_step = {1'b0, r_man_small[SW-1:2], r_man_small[1] | r_man_small[0]};
        w_cnt_step       = r_cnt - CNT_W'(1);
`ifdef ALIGN_COARSE_EN
        if (r_cnt >= CNT_W'(4)) begin
            w_man_small_step = {4'b0000, r_man_small[SW-1:5], |r_man_small[4:0]};
            w_cnt_step       = r_cnt - CNT_W'(4);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept, shift until the count drains, then hold the
    // result until the downstream stage takes it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture the operands with swap on accept, then shift the small
    // mantissa each cycle while the count is nonzero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_man_small <= '0;
            r_man_big   <= '0;
            r_exp_out   <= '0;
            r_swapped   <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_init;
            if (i_a_ge_b) begin
                r_man_big   <= i_man_a;
                r_man_small <= {i_man_b, 3'b000};
                r_exp_out   <= i_exp_a;
                r_swapped   <= 1'b0;
            end else begin
                r_man_big   <= i_man_b;
                r_man_small <= {i_man_a, 3'b000};
                r_exp_out   <= i_exp_b;
                r_swapped   <= 1'b1;
            end
        end else if (w_shifting) begin
            r_man_small <= w_man_small_step;
            r_cnt       <= w_cnt_step;
        end
    end

    // Result-valid flag. It is registered together with the DONE state so it
    // rises on the same edge the FSM enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_fp_align_shifter.sv
// tb_fp_align_shifter: self-checking bench for the alignment shifter.
// It runs directed vectors, randomized operations checked against an arithmetic
// model, a backpressure sequence and an asynchronous reset in the middle of a shift.
module tb_fp_align_shifter;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int SW     = MANT_W + 3;

    logic                clk;
    logic                rst_n;
    logic                i_in_valid;
    logic                o_in_ready;
    logic [EXP_W-1:0]    i_exp_diff;
    logic                i_a_ge_b;
    logic [EXP_W-1:0]    i_exp_a;
    logic [EXP_W-1:0]    i_exp_b;
    logic [MANT_W-1:0]   i_man_a;
    logic [MANT_W-1:0]   i_man_b;
    logic                o_out_valid;
    logic                i_out_ready;
    logic [EXP_W-1:0]    o_exp_out;
    logic [MANT_W-1:0]   o_man_big;
    logic [SW-1:0]       o_man_small;
    logic                o_swapped;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              aGeB;
        logic [EXP_W-1:0]  diff;
        logic [EXP_W-1:0]  expA;
        logic [EXP_W-1:0]  expB;
        logic [MANT_W-1:0] manA;
        logic [MANT_W-1:0] manB;
        logic [EXP_W-1:0]  eExp;
        logic [MANT_W-1:0] eBig;
        logic [SW-1:0]     eSmall;
        logic              eSw;
        int                eLat;
    } vec_t;

    vec_t vecs[6];

    fp_align_shifter #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_exp_diff  (i_exp_diff),
        .i_a_ge_b    (i_a_ge_b),
        .i_exp_a     (i_exp_a),
        .i_exp_b     (i_exp_b),
        .i_man_a     (i_man_a),
        .i_man_b     (i_man_b),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_exp_out   (o_exp_out),
        .o_man_big   (o_man_big),
        .o_man_small (o_man_small),
        .o_swapped   (o_swapped)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference alignment: the value shifted right by the clamped distance,
    // with bit 0 ORed with every bit that fell off the bottom.
    function automatic logic [SW-1:0] modelSmall(input logic [MANT_W-1:0] m, input int d);
        logic [63:0] full;
        logic [63:0] res;
        int dd;
        full = {40'd0, m, 3'b000};
        dd   = (d > SW) ? SW : d;
        res  = full >> dd;
        if ((full & ((64'd1 << dd) - 64'd1)) != 64'd0) res = res | 64'd1;
        return res[SW-1:0];
    endfunction

    // Reference latency, counted from the accept edge to the out_valid edge inclusive.
    function automatic int modelLat(input int d);
        int dd;
        dd = (d > SW) ? SW : d;
`ifdef ALIGN_COARSE_EN
        return dd / 4 + dd % 4 + 2;
`else
        return dd + 2;
`endif
    endfunction

    // Scramble the operand inputs so that any leak after accept shows up.
    task automatic scrambleInputs();
        i_exp_diff = EXP_W'($urandom);
        i_a_ge_b   = 1'($urandom);
        i_exp_a    = EXP_W'($urandom);
        i_exp_b    = EXP_W'($urandom);
        i_man_a    = MANT_W'($urandom);
        i_man_b    = MANT_W'($urandom);
    endtask

    // Hand one operand set over and wait (bounded) for out_valid. Return the
    // number of edges counted from the accept edge inclusive.
    task automatic applyStimulus(input vec_t v, output int lat);
        int guard;
        guard = 0;
        while (!o_in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        checkOutput("in_ready before accept", 64'(o_in_ready), 64'd1);
        i_a_ge_b   = v.aGeB;
        i_exp_diff = v.diff;
        i_exp_a    = v.expA;
        i_exp_b    = v.expB;
        i_man_a    = v.manA;
        i_man_b    = v.manB;
        i_in_valid = 1'b1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        scrambleInputs();
        lat = 1;
        while (!o_out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    // Check all result fields against a vector's expectations.
    task automatic checkResult(input vec_t v, input int lat, input string tag);
        checkOutput({tag, " latency"},   64'(lat),         64'(v.eLat));
        checkOutput({tag, " exp_out"},   64'(o_exp_out),   64'(v.eExp));
        checkOutput({tag, " man_big"},   64'(o_man_big),   64'(v.eBig));
        checkOutput({tag, " man_small"}, 64'(o_man_small), 64'(v.eSmall));
        checkOutput({tag, " swapped"},   64'(o_swapped),   64'(v.eSw));
    endtask

    // Pulse out_ready for one cycle. The block must then be idle again.
    task automatic releaseResult(input string tag);
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        checkOutput({tag, " out_valid after take"}, 64'(o_out_valid), 64'd0);
        checkOutput({tag, " in_ready after take"},  64'(o_in_ready),  64'd1);
    endtask

    // Build a vector from exponents and mantissas using the model.
    function automatic vec_t makeVec(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb,
                                     input logic [MANT_W-1:0] ma, input logic [MANT_W-1:0] mb);
        vec_t v;
        int d;
        v.aGeB   = (ea >= eb);
        d        = v.aGeB ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
        v.diff   = EXP_W'(d);
        v.expA   = ea;
        v.expB   = eb;
        v.manA   = ma;
        v.manB   = mb;
        v.eExp   = v.aGeB ? ea : eb;
        v.eBig   = v.aGeB ? ma : mb;
        v.eSmall = modelSmall(v.aGeB ? mb : ma, d);
        v.eSw    = !v.aGeB;
        v.eLat   = modelLat(d);
        return v;
    endfunction

    initial begin
        int lat;
        vec_t v;
        logic [EXP_W-1:0]  holdExp;
        logic [MANT_W-1:0] holdBig;
        logic [SW-1:0]     holdSmall;
        logic              holdSw;

        // Directed vectors with hand-computed expectations.
        vecs[0] = '{1'b1, 8'd0,   8'h80, 8'h80, 24'h800000, 24'hC00000, 8'h80, 24'h800000, 27'h6000000, 1'b0, 2};
        vecs[1] = '{1'b1, 8'd3,   8'h83, 8'h80, 24'hA00000, 24'h800001, 8'h83, 24'hA00000, 27'h0800001, 1'b0, 5};
`ifdef ALIGN_COARSE_EN
        vecs[2] = '{1'b0, 8'd128, 8'h10, 8'h90, 24'hFFFFFF, 24'h900000, 8'h90, 24'h900000, 27'h0000001, 1'b1, 11};
        vecs[3] = '{1'b1, 8'd27,  8'h9B, 8'h80, 24'h800000, 24'h800000, 8'h9B, 24'h800000, 27'h0000001, 1'b0, 11};
        vecs[4] = '{1'b1, 8'd4,   8'h84, 8'h80, 24'hC00000, 24'h800003, 8'h84, 24'hC00000, 27'h0400001, 1'b0, 3};
`else
        vecs[2] = '{1'b0, 8'd128, 8'h10, 8'h90, 24'hFFFFFF, 24'h900000, 8'h90, 24'h900000, 27'h0000001, 1'b1, 29};
        vecs[3] = '{1'b1, 8'd27,  8'h9B, 8'h80, 24'h800000, 24'h800000, 8'h9B, 24'h800000, 27'h0000001, 1'b0, 29};
        vecs[4] = '{1'b1, 8'd4,   8'h84, 8'h80, 24'hC00000, 24'h800003, 8'h84, 24'hC00000, 27'h0400001, 1'b0, 6};
`endif
        vecs[5] = '{1'b0, 8'd1,   8'h40, 8'h41, 24'hFFFFFF, 24'hABCDEF, 8'h41, 24'hABCDEF, 27'h3FFFFFC, 1'b1, 3};

        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        scrambleInputs();
        repeat (2) @(posedge clk);
        #1;
        // Reset state.
        checkOutput("reset in_ready",  64'(o_in_ready),  64'd1);
        checkOutput("reset out_valid", 64'(o_out_valid), 64'd0);
        checkOutput("reset exp_out",   64'(o_exp_out),   64'd0);
        checkOutput("reset man_big",   64'(o_man_big),   64'd0);
        checkOutput("reset man_small", 64'(o_man_small), 64'd0);
        checkOutput("reset swapped",   64'(o_swapped),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], lat);
            checkResult(vecs[i], lat, $sformatf("vec%0d", i));
            releaseResult($sformatf("vec%0d", i));
        end

        // Randomized operations against the model. Some exponent gaps are
        // forced large to exercise saturation.
        for (int i = 0; i < 40; i++) begin
            logic [EXP_W-1:0] ea, eb;
            ea = EXP_W'($urandom);
            eb = (i % 4 == 0) ? EXP_W'($urandom) : EXP_W'(int'(ea) + $urandom_range(0, 30) - 15);
            v = makeVec(ea, eb, MANT_W'($urandom), MANT_W'($urandom));
            applyStimulus(v, lat);
            checkResult(v, lat, $sformatf("rand%0d", i));
            releaseResult($sformatf("rand%0d", i));
        end

        // Backpressure: hold out_ready low and offer new operands meanwhile.
        v = makeVec(8'h85, 8'h80, 24'h812345, 24'hF0F0F1);
        applyStimulus(v, lat);
        checkResult(v, lat, "bp");
        holdExp   = o_exp_out;
        holdBig   = o_man_big;
        holdSmall = o_man_small;
        holdSw    = o_swapped;
        for (int c = 0; c < 5; c++) begin
            scrambleInputs();
            i_in_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput("bp out_valid", 64'(o_out_valid), 64'd1);
            checkOutput("bp in_ready",  64'(o_in_ready),  64'd0);
            checkOutput("bp exp_out",   64'(o_exp_out),   64'(v.eExp));
            checkOutput("bp man_small", 64'(o_man_small), 64'(v.eSmall));
            checkOutput("bp hold", 64'({holdExp, holdBig, holdSw} != {o_exp_out, o_man_big, o_swapped}
                                        || holdSmall != o_man_small), 64'd0);
        end
        i_in_valid = 1'b0;
        releaseResult("bp");

        // Reset pulse in the third cycle of a 20-bit shift.
        v = makeVec(8'h94, 8'h80, 24'h9ABCDE, 24'hFEDCBA);
        i_a_ge_b   = v.aGeB;
        i_exp_diff = v.diff;
        i_exp_a    = v.expA;
        i_exp_b    = v.expB;
        i_man_a    = v.manA;
        i_man_b    = v.manB;
        i_in_valid = 1'b1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midshift in_ready", 64'(o_in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 64'(o_out_valid), 64'd0);
        checkOutput("abort in_ready",  64'(o_in_ready),  64'd1);
        checkOutput("abort man_small", 64'(o_man_small), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post-reset in_ready",  64'(o_in_ready),  64'd1);
        checkOutput("post-reset out_valid", 64'(o_out_valid), 64'd0);
        applyStimulus(v, lat);
        checkResult(v, lat, "post-reset");
        releaseResult("post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
